// File: rtl/dmem_responder.sv
// dmem_responder
//   Data-memory responder for the single-cycle RISC-V core. Captures one
//   load/store request, waits WAIT_STATES cycles, then returns a one-cycle
//   ready strobe. Handles byte-lane steering for SB/SH/SW, sign/zero
//   extension for LB/LH/LW/LBU/LHU, and rejects illegal or misaligned
//   accesses with err.
//
//   Ports
//     CLK, RSTn       clock (rising edge), async active-low reset
//     MemRead         load request
//     MemWrite        store request
//     addr            byte address
//     funct3          access size/sign (instruction[14:12])
//     write_data      right-aligned store data
//     read_data       registered, extended load result
//     ready           one-cycle response strobe
//     err             access rejected, only valid with ready
//
//   state  | meaning
//   -------+---------------------------------------------------------
//   S_IDLE | waiting for MemRead/MemWrite, captures request
//   S_WAIT | counting down wait states, inputs ignored
//   S_RESP | ready high for one cycle, then back to S_IDLE

module dmem_responder #(
    parameter int ADDR_W      = 12,
    parameter int WAIT_STATES = 1
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        funct3,
    input  logic [31:0]       write_data,
    output logic [31:0]       read_data,
    output logic              ready,
    output logic              err
);

    localparam int DEPTH = 1 << (ADDR_W - 2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                rd_q, rd_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [2:0]          f3_q, f3_d;
    logic [31:0]         wd_q, wd_d;
    logic                err_q, err_d;
    logic [31:0]         rdata_q, rdata_d;

    logic [31:0]         mem [DEPTH];

    // With zero wait states the response is committed on the capture edge,
    // so the live inputs must be used there instead of the captured copy.
    logic                in_idle;
    logic                eff_rd, eff_wr;
    logic [ADDR_W-1:0]   eff_addr;
    logic [2:0]          eff_f3;
    logic [31:0]         eff_wd;
    logic [1:0]          lane;
    logic [ADDR_W-3:0]   idx;
    logic [31:0]         mem_word, sh_word, load_val, wd_sh;
    logic [3:0]          be;
    logic                acc_err, f3_bad, misaligned;
    logic                commit, mem_we;

    assign in_idle  = (state_q == S_IDLE);
    assign eff_rd   = in_idle ? MemRead    : rd_q;
    assign eff_wr   = in_idle ? MemWrite   : wr_q;
    assign eff_addr = in_idle ? addr       : addr_q;
    assign eff_f3   = in_idle ? funct3     : f3_q;
    assign eff_wd   = in_idle ? write_data : wd_q;

    assign lane     = eff_addr[1:0];
    assign idx      = eff_addr[ADDR_W-1:2];
    assign mem_word = mem[idx];
    assign sh_word  = mem_word >> {lane, 3'b000};
    assign wd_sh    = eff_wd << {lane, 3'b000};

    always_comb begin
        f3_bad = 1'b0;
        if (eff_rd) begin
            f3_bad = (eff_f3 == 3'b011) || (eff_f3 == 3'b110) || (eff_f3 == 3'b111);
        end else begin
            f3_bad = eff_f3[2] || (eff_f3[1:0] == 2'b11);
        end
    end

    always_comb begin
        misaligned = 1'b0;
        case (eff_f3[1:0])
            2'b01:   misaligned = lane[0];
            2'b10:   misaligned = (lane != 2'b00);
            default: misaligned = 1'b0;
        endcase
    end

    assign acc_err = (eff_rd && eff_wr) || f3_bad || misaligned;

    always_comb begin
        load_val = 32'h0;
        case (eff_f3)
            3'b000:  load_val = {{24{sh_word[7]}}, sh_word[7:0]};
            3'b001:  load_val = {{16{sh_word[15]}}, sh_word[15:0]};
            3'b010:  load_val = sh_word;
            3'b100:  load_val = {24'h0, sh_word[7:0]};
            3'b101:  load_val = {16'h0, sh_word[15:0]};
            default: load_val = 32'h0;
        endcase
    end

    always_comb begin
        be = 4'b0000;
        case (eff_f3[1:0])
            2'b00:   be = 4'b0001 << lane;
            2'b01:   be = 4'b0011 << lane;
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        f3_d    = f3_q;
        wd_d    = wd_q;
        err_d   = 1'b0;
        rdata_d = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (MemRead || MemWrite) begin
                    rd_d   = MemRead;
                    wr_d   = MemWrite;
                    addr_d = addr;
                    f3_d   = funct3;
                    wd_d   = write_data;
                    cnt_d  = 4'(WAIT_STATES);
                    if (WAIT_STATES == 0) state_d = S_RESP;
                    else                  state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        commit = (state_d == S_RESP) && (state_q != S_RESP);

        if (commit) begin
            err_d = acc_err;
            if (acc_err)     rdata_d = 32'h0;
            else if (eff_rd) rdata_d = load_val;
        end
    end

    assign mem_we = commit && eff_wr && !acc_err;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            f3_q    <= 3'b000;
            wd_q    <= 32'h0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            f3_q    <= f3_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Array has no reset; a store is dropped if reset is held on its commit edge.
    always_ff @(posedge CLK) begin
        if (mem_we && RSTn) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wd_sh[8*b +: 8];
            end
        end
    end

    assign ready     = (state_q == S_RESP);
    assign err       = err_q && ready;
    assign read_data = rdata_q;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the single-cycle RISC-V core. It receives the core's load/store requests (MemRead/MemWrite, byte address, write data, funct3) and serves them from an internal word array. It returns sign- or zero-extended load data with a one-cycle `ready` pulse after a programmable number of wait states. It sits between the core's DMEM port and the on-chip data RAM, and owns byte-lane steering and alignment checking.

## Interface
- `ADDR_W`, default 12: byte-address width; array depth is 2^(ADDR_W-2) 32-bit words.
- `WAIT_STATES`, default 1: extra cycles between request capture and response, range 0..15.
- `CLK`  in  1: clock, rising edge.
- `RSTn`  in  1: reset, asynchronous, active-low.
- `MemRead`  in  1: load request.
- `MemWrite`  in  1: store request.
- `addr`  in  ADDR_W: byte address.
- `funct3`  in  3: access size/sign, from instruction[14:12].
- `write_data`  in  32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `read_data`  out  32: load result, extended to 32 bits.
- `ready`  out  1: one-cycle response strobe.
- `err`  out  1: qualifies `ready`; the access was rejected.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If `MemRead` or `MemWrite` is high at a rising edge, capture op, `addr`, `funct3` and `write_data`.
  - Load the wait counter with WAIT_STATES.
  - Go to WAIT if WAIT_STATES>0, else RESP.
- WAIT:
  - Decrement the counter each cycle; go to RESP on the edge where the counter is 1.
  - Inputs are ignored; captured values are used.
- RESP:
  - `ready`=1 for exactly one cycle, then unconditionally go to IDLE.
- Legal loads, per funct3:
  - 000 LB: sign-extend.
  - 001 LH: sign-extend.
  - 010 LW.
  - 100 LBU: zero-extend.
  - 101 LHU: zero-extend.
- Legal stores, per funct3: 000 SB, 001 SH, 010 SW.
- Byte lane = addr[1:0]; word index = addr[ADDR_W-1:2].
- A store writes only the selected lanes: SB 1 lane, SH lanes {1:0} or {3:2}, SW all 4. Other bytes are preserved.
- Error conditions (`err`=1 with `ready`; no array write; `read_data` forced to 0):
  - MemRead and MemWrite both high at capture.
  - Illegal funct3 for the op.
  - Misaligned access: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0.
- Store commit: the array is written on the same edge that enters RESP, never earlier.
- `read_data`: registered and updated on the RESP-entry edge for loads only. It holds its value through stores and idle cycles.
- Array contents are not reset.

## Timing
- Reset values: state IDLE, counter 0, `ready`=0, `err`=0, `read_data`=0.
- A request present at edge N gives `ready` high during cycle N+1+WAIT_STATES. Example: WAIT_STATES=0 responds the cycle after capture; WAIT_STATES=1 responds two cycles after.
- Requester handshake:
  - Hold the request stable until `ready` is seen.
  - Deassert it in the cycle after `ready`, or keep it asserted to issue the next access.
  - A request still high in the cycle after RESP is captured in IDLE as a new access.
- Maximum throughput: one access per WAIT_STATES+2 cycles.
- Read-after-write to the same word in back-to-back transactions returns the new data; the write has already committed.
- Request changes during WAIT/RESP are ignored.
- Reset asserted mid-transaction:
  - Return immediately to IDLE with outputs at reset values.
  - A store not yet in RESP is discarded; a store already committed stays in the array.
- `err` is 0 whenever `ready` is 0.

## Test plan
- Reset, then SW 0xDEADBEEF @0x010, then LW @0x010 → `read_data`=0xDEADBEEF, `err`=0. With WAIT_STATES=1, `ready` is seen 2 cycles after each capture.
- SB 0x7F @0x011, then LW @0x010 → 0xDEAD7FEF. Then LB @0x013 → 0xFFFFFFDE, and LBU @0x013 → 0x000000DE.
- SH 0x8001 @0x012, then LH @0x012 → 0xFFFF8001, and LHU → 0x00008001.
- Misalignment and illegal funct3:
  - LW @0x011 → `ready`=1, `err`=1, `read_data`=0.
  - SH @0x013 → `err`=1 and the array word is unchanged (verify via LW).
  - funct3=011 → `err`=1.
- Error on both ops: MemRead=MemWrite=1 → `err`=1 and no write.
- Reset during WAIT of SW 0x12345678 @0x020 (WAIT_STATES=3, prior content 0), then after release LW @0x020 → 0x00000000. A request held continuously yields one `ready` every WAIT_STATES+2 cycles.
